ball_ctrl: RTL

BALL_CTRL -- requirements
Module: ball_ctrl

---
 rtl/ball_pkg.sv | 19 +
 rtl/ball_render.sv | 47 ++++
 rtl/ball_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared constants and FSM state type for the ball controller and its renderer.
package ball_pkg;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned BALL_SIZE = 8;
    localparam int unsigned PAD_X_L   = 600;
    localparam int unsigned PAD_X_R   = 603;
    localparam int unsigned START_X   = 316;
    localparam int unsigned START_Y   = 236;
    localparam int unsigned POS_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MISS = 2'd2
    } state_e;

endpackage

// File: rtl/ball_render.sv
// Sprite rendering: 8x8 box test, ROM row/column selection and registered pixel output.
module ball_render
    import ball_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [POS_W-1:0] pixel_x_i,
    input  logic [POS_W-1:0] pixel_y_i,
    input  logic             video_on_i,
    input  logic [POS_W-1:0] x_l_i,
    input  logic [POS_W-1:0] y_t_i,
    input  logic             hide_i,
    input  logic [7:0]       rom_data_i,
    output logic [2:0]       rom_addr_o,
    output logic             ball_on_o
);

    logic [POS_W-1:0] dx_pix;
    logic [POS_W-1:0] dy_pix;
    logic [2:0]       col;
    logic             in_box;
    logic             ball_on_d;
    logic             ball_on_q;

    // Offsets are only meaningful when the pixel is at or right/below the box corner.
    always_comb begin
        dx_pix    = pixel_x_i - x_l_i;
        dy_pix    = pixel_y_i - y_t_i;
        col       = dx_pix[2:0];
        in_box    = (pixel_x_i >= x_l_i) && (pixel_y_i >= y_t_i) &&
                    (dx_pix < POS_W'(BALL_SIZE)) && (dy_pix < POS_W'(BALL_SIZE));
        ball_on_d = video_on_i && in_box && !hide_i && rom_data_i[3'd7 - col];
    end

    assign rom_addr_o = dy_pix[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ball_on_q <= 1'b0;
        end else begin
            ball_on_q <= ball_on_d;
        end
    end

    assign ball_on_o = ball_on_q;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball motion, wall/paddle reflection and serve/miss FSM; rendering lives in ball_render.
// Optional feature: define BALL_SPEEDUP_EN to speed the ball up every fourth paddle hit.
module ball_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned BALL_V      = 2,
    parameter int unsigned MISS_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refresh_tick,
    input  logic       start,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic [9:0] paddle_y_t,
    input  logic [9:0] paddle_y_b,
    output logic [2:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       ball_on,
    output logic       hit,
    output logic       miss,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(MISS_FRAMES + 1);
    localparam int unsigned EXT_W = POS_W + 1;

    state_e           state_q, state_d;
    logic [POS_W-1:0] x_l_q, x_l_d;
    logic [POS_W-1:0] y_t_q, y_t_d;
    logic             dx_q, dx_d;   // 1 = moving +x
    logic             dy_q, dy_d;   // 1 = moving +y
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             busy_q, busy_d;

    logic [POS_W-1:0] speed;
    logic [EXT_W-1:0] spd_x, x_r, y_b;
    logic             top_wall, bot_wall, left_wall, pad_hit, escaped;

`ifdef BALL_SPEEDUP_EN
    logic [1:0]       hit_cnt_q, hit_cnt_d;
    logic [POS_W-1:0] speed_q, speed_d;
    assign speed = speed_q;
`else
    assign speed = POS_W'(BALL_V);
`endif

    // Edge arithmetic is one bit wider so x_r/y_b never wrap.
    assign spd_x     = {1'b0, speed};
    assign x_r       = {1'b0, x_l_q} + EXT_W'(BALL_SIZE - 1);
    assign y_b       = {1'b0, y_t_q} + EXT_W'(BALL_SIZE - 1);
    assign top_wall  = {1'b0, y_t_q} <= spd_x;
    assign bot_wall  = y_b >= (EXT_W'(SCREEN_H - 1) - spd_x);
    assign left_wall = {1'b0, x_l_q} <= spd_x;
    assign escaped   = x_r > EXT_W'(SCREEN_W - 1);
    assign pad_hit   = dx_q && (x_r >= EXT_W'(PAD_X_L)) && (x_r <= EXT_W'(PAD_X_R)) &&
                       (y_t_q <= paddle_y_b) && (y_b >= {1'b0, paddle_y_t});

    always_comb begin
        state_d = state_q;
        x_l_d   = x_l_q;
        y_t_d   = y_t_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
`ifdef BALL_SPEEDUP_EN
        hit_cnt_d = hit_cnt_q;
        speed_d   = speed_q;
`endif
        case (state_q)
            ST_IDLE: begin
                x_l_d = POS_W'(START_X);
                y_t_d = POS_W'(START_Y);
                dx_d  = 1'b1;
                dy_d  = 1'b1;
                cnt_d = '0;
`ifdef BALL_SPEEDUP_EN
                hit_cnt_d = '0;
                speed_d   = POS_W'(BALL_V);
`endif
                if (refresh_tick && start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (escaped) begin
                    state_d = ST_MISS;
                    miss_d  = 1'b1;
                    cnt_d   = '0;
                end else if (refresh_tick) begin
                    // Reflections settle the direction first, then this tick's step uses it.
                    if (top_wall) begin
                        dy_d = 1'b1;
                    end else if (bot_wall) begin
                        dy_d = 1'b0;
                    end
                    if (left_wall) begin
                        dx_d = 1'b1;
                    end
                    if (pad_hit) begin
                        dx_d  = 1'b0;
                        hit_d = 1'b1;
                    end
                    x_l_d = dx_d ? (x_l_q + speed) : (x_l_q - speed);
                    y_t_d = dy_d ? (y_t_q + speed) : (y_t_q - speed);
`ifdef BALL_SPEEDUP_EN
                    if (pad_hit) begin
                        hit_cnt_d = hit_cnt_q + 2'd1;
                        if ((hit_cnt_q == 2'd3) && (speed_q < POS_W'(BALL_V + 2))) begin
                            speed_d = speed_q + POS_W'(1);
                        end
                    end
`endif
                end
            end
            ST_MISS: begin
                if (refresh_tick) begin
                    if (cnt_q == CNT_W'(MISS_FRAMES - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        x_l_d   = POS_W'(START_X);
                        y_t_d   = POS_W'(START_Y);
                        dx_d    = 1'b1;
                        dy_d    = 1'b1;
`ifdef BALL_SPEEDUP_EN
                        hit_cnt_d = '0;
                        speed_d   = POS_W'(BALL_V);
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            x_l_q   <= POS_W'(START_X);
            y_t_q   <= POS_W'(START_Y);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            hit_cnt_q <= '0;
            speed_q   <= POS_W'(BALL_V);
`endif
        end else begin
            state_q <= state_d;
            x_l_q   <= x_l_d;
            y_t_q   <= y_t_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            busy_q  <= busy_d;
`ifdef BALL_SPEEDUP_EN
            hit_cnt_q <= hit_cnt_d;
            speed_q   <= speed_d;
`endif
        end
    end

    assign hit  = hit_q;
    assign miss = miss_q;
    assign busy = busy_q;

    ball_render u_render (
        .clk        (clk),
        .reset_n    (reset_n),
        .pixel_x_i  (pixel_x),
        .pixel_y_i  (pixel_y),
        .video_on_i (video_on),
        .x_l_i      (x_l_q),
        .y_t_i      (y_t_q),
        .hide_i     (state_q == ST_MISS),
        .rom_data_i (rom_data),
        .rom_addr_o (rom_addr),
        .ball_on_o  (ball_on)
    );

endmodule
